// File: rtl/adv7513_pkg.sv
// adv7513_pkg: shared types and constants for the ADV7513 init sequencer.
//   state_t       - sequencer state encoding
//   REG_*/DAT_*   - bit positions of reg_addr/data inside a 16-bit table entry
//   I2C_STATUS_OK - i2c_master status code for a clean transaction
//   cnt_width()   - width of a down-counter holding 0..max_val (minimum 1)
package adv7513_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_CHECK  = 3'd4,
      S_DELAY  = 3'd5,
      S_VERIFY = 3'd6
   } state_t;

   localparam int unsigned REG_HI = 15;
   localparam int unsigned REG_LO = 8;
   localparam int unsigned DAT_HI = 7;
   localparam int unsigned DAT_LO = 0;

   localparam logic [2:0] I2C_STATUS_OK = 3'd0;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/adv7513_init_rom.sv
// adv7513_init_rom: combinational power-up register table for the ADV7513.
// Ports:
//   tbl_idx   (in,  IDX_W) - table index
//   tbl_entry (out, 16)    - {reg_addr, data}; zero beyond the last entry
module adv7513_init_rom
   import adv7513_pkg::*;
#(
   parameter int unsigned IDX_W = 8
) (
   input  logic [IDX_W-1:0] tbl_idx,
   output logic [15:0]      tbl_entry
);

   always_comb begin
      tbl_entry = 16'h0000;
      case (tbl_idx)
         IDX_W'(0):  tbl_entry = {8'h41, 8'h10};
         IDX_W'(1):  tbl_entry = {8'h98, 8'h03};
         IDX_W'(2):  tbl_entry = {8'h9A, 8'hE0};
         IDX_W'(3):  tbl_entry = {8'h9C, 8'h30};
         IDX_W'(4):  tbl_entry = {8'h9D, 8'h61};
         IDX_W'(5):  tbl_entry = {8'hA2, 8'hA4};
         IDX_W'(6):  tbl_entry = {8'hA3, 8'hA4};
         IDX_W'(7):  tbl_entry = {8'hE0, 8'hD0};
         IDX_W'(8):  tbl_entry = {8'hF9, 8'h00};
         IDX_W'(9):  tbl_entry = {8'h15, 8'h00};
         IDX_W'(10): tbl_entry = {8'h16, 8'h30};
         IDX_W'(11): tbl_entry = {8'h17, 8'h02};
         IDX_W'(12): tbl_entry = {8'h18, 8'h46};
         IDX_W'(13): tbl_entry = {8'hAF, 8'h06};
         IDX_W'(14): tbl_entry = {8'hBA, 8'h60};
         IDX_W'(15): tbl_entry = {8'hD6, 8'hC0};
         default:    tbl_entry = 16'h0000;
      endcase
   end

endmodule

// File: rtl/adv7513_init_seq.sv
// adv7513_init_seq: programs the ADV7513 after hot-plug by walking a
// register/data table and issuing one i2c_master write per entry, with
// per-entry retries, a transaction timeout and an inter-transaction gap.
// Optional macro ADV7513_INIT_VERIFY_EN adds a read-back of every write.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start, hpd                  - sequence request, synchronised hot-plug detect
//   done, error, err_idx        - sticky status and failing table index
//   tbl_idx, tbl_entry          - external table port (used when USE_EXT_TABLE)
//   i2c_chip_addr/reg_addr/data_in, i2c_write_en/read_en - request to i2c_master
//   i2c_busy, i2c_status, i2c_data_out                   - response from i2c_master
module adv7513_init_seq
   import adv7513_pkg::*;
#(
   parameter logic [6:0]  CHIP_ADDR     = 7'h72,
   parameter int unsigned NUM_REGS      = 16,
   parameter int unsigned IDX_W         = 8,
   parameter int unsigned TXN_DELAY     = 1000,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned TIMEOUT       = 65535,
   parameter bit          USE_EXT_TABLE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             hpd,
   output logic             done,
   output logic             error,
   output logic [IDX_W-1:0] err_idx,
   output logic [IDX_W-1:0] tbl_idx,
   input  logic [15:0]      tbl_entry,
   output logic [6:0]       i2c_chip_addr,
   output logic [7:0]       i2c_reg_addr,
   output logic [7:0]       i2c_data_in,
   output logic             i2c_write_en,
   output logic             i2c_read_en,
   input  logic             i2c_busy,
   input  logic [2:0]       i2c_status,
   input  logic [7:0]       i2c_data_out
);

   localparam int unsigned DLY_W = cnt_width(TXN_DELAY);
   localparam int unsigned TMO_W = cnt_width(TIMEOUT);
   localparam int unsigned RTY_W = cnt_width(MAX_RETRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   state_t           state;
   logic [DLY_W-1:0] dly_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [RTY_W-1:0] retries;
   logic             first_wait;
   logic             timed_out;
   logic             succ;
   logic             hpd_lost;
   logic             aborting;
   logic             txn_ok;
   logic [15:0]      rom_entry;
   logic [15:0]      entry;

   adv7513_init_rom #(.IDX_W(IDX_W)) u_rom (
      .tbl_idx   (tbl_idx),
      .tbl_entry (rom_entry)
   );

   assign entry = USE_EXT_TABLE ? tbl_entry : rom_entry;

   // hot-plug loss is sticky for the rest of the sequence
   assign aborting = hpd_lost | ~hpd;

`ifdef ADV7513_INIT_VERIFY_EN
   logic verifying;

   // a read-back passes only if the returned byte matches what was written
   always_comb begin
      txn_ok = (i2c_status == I2C_STATUS_OK) && !timed_out;
      if (verifying && (i2c_data_out != i2c_data_in)) txn_ok = 1'b0;
   end
`else
   logic [7:0] unused_data_out;
   assign unused_data_out = i2c_data_out;

   always_comb begin
      txn_ok = (i2c_status == I2C_STATUS_OK) && !timed_out;
   end
`endif

   // sequencer state machine with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         done          <= 1'b0;
         error         <= 1'b0;
         err_idx       <= '0;
         tbl_idx       <= '0;
         i2c_write_en  <= 1'b0;
         i2c_read_en   <= 1'b0;
         i2c_reg_addr  <= 8'h00;
         i2c_data_in   <= 8'h00;
         i2c_chip_addr <= CHIP_ADDR;
         dly_cnt       <= '0;
         tmo_cnt       <= '0;
         retries       <= '0;
         first_wait    <= 1'b0;
         timed_out     <= 1'b0;
         succ          <= 1'b0;
         hpd_lost      <= 1'b0;
`ifdef ADV7513_INIT_VERIFY_EN
         verifying     <= 1'b0;
`endif
      end else begin
         if ((state != S_IDLE) && !hpd) hpd_lost <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start && hpd) begin
                  done     <= 1'b0;
                  error    <= 1'b0;
                  tbl_idx  <= '0;
                  retries  <= '0;
                  hpd_lost <= 1'b0;
                  state    <= S_LOAD;
               end
            end

            // entry has had a full cycle to settle since tbl_idx changed;
            // the pulse is held off while a timed-out transfer is still busy
            S_LOAD: begin
               i2c_reg_addr <= entry[REG_HI:REG_LO];
               i2c_data_in  <= entry[DAT_HI:DAT_LO];
               if (aborting) begin
                  state <= S_IDLE;
               end else if (!i2c_busy) begin
                  i2c_write_en <= 1'b1;
`ifdef ADV7513_INIT_VERIFY_EN
                  verifying    <= 1'b0;
`endif
                  state        <= S_ISSUE;
               end
            end

            // request pulse is visible during this state
            S_ISSUE: begin
               i2c_write_en <= 1'b0;
               i2c_read_en  <= 1'b0;
               tmo_cnt      <= TMO_W'(TIMEOUT);
               first_wait   <= 1'b1;
               timed_out    <= 1'b0;
               state        <= S_WAIT;
            end

            // busy may lag the pulse by a cycle, so the first cycle is skipped
            S_WAIT: begin
               if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
               if (first_wait) begin
                  first_wait <= 1'b0;
               end else if (!i2c_busy) begin
                  state <= S_CHECK;
               end else if (tmo_cnt == '0) begin
                  timed_out <= 1'b1;
                  state     <= S_CHECK;
               end
            end

            S_CHECK: begin
               dly_cnt <= DLY_W'(TXN_DELAY);
               if (aborting) begin
                  state <= S_IDLE;
               end else if (txn_ok) begin
`ifdef ADV7513_INIT_VERIFY_EN
                  if (!verifying) begin
                     state <= S_VERIFY;
                  end else begin
                     succ  <= 1'b1;
                     state <= S_DELAY;
                  end
`else
                  succ  <= 1'b1;
                  state <= S_DELAY;
`endif
               end else if (retries < RTY_W'(MAX_RETRIES)) begin
                  retries <= retries + RTY_W'(1);
                  succ    <= 1'b0;
                  state   <= S_DELAY;
               end else begin
                  error   <= 1'b1;
                  err_idx <= tbl_idx;
                  state   <= S_IDLE;
               end
            end

`ifdef ADV7513_INIT_VERIFY_EN
            // read back the register just written, reusing the issue/wait path
            S_VERIFY: begin
               if (aborting) begin
                  state <= S_IDLE;
               end else if (!i2c_busy) begin
                  i2c_read_en <= 1'b1;
                  verifying   <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
`endif

            // one cycle here plus TXN_DELAY countdown cycles
            S_DELAY: begin
               if (aborting) begin
                  state <= S_IDLE;
               end else if (dly_cnt != '0) begin
                  dly_cnt <= dly_cnt - DLY_W'(1);
               end else if (!succ) begin
                  state <= S_LOAD;
               end else if (tbl_idx == LAST_IDX) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  tbl_idx <= tbl_idx + IDX_W'(1);
                  retries <= '0;
                  state   <= S_LOAD;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/adv7513_init_seq.md
Name: adv7513_init_seq

Overview:
- Sequencer that programs the ADV7513 HDMI transmitter after hot-plug: walks a register/data table and issues one `i2c_master` write per entry.
- Retries NACKed transactions and enforces a programmable inter-transaction gap.
- Reports done/error to the top-level video bring-up logic.
- Owns the `i2c_master` request interface. Exactly one request is outstanding at any time.

Parameters:
- CHIP_ADDR, 7'h72, 7-bit I2C device address driven on i2c_chip_addr
- NUM_REGS, 16, number of table entries (1..256)
- IDX_W, 8, width of tbl_idx; must satisfy 2^IDX_W >= NUM_REGS
- TXN_DELAY, 1000, idle clk cycles between transactions (0 allowed)
- MAX_RETRIES, 3, retries per entry after the first attempt
- TIMEOUT, 65535, clk cycles an i2c transaction may stay busy before it counts as failed

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- start, in, 1, begin sequence (level or pulse; sampled only in S_IDLE)
- hpd, in, 1, hot-plug detect, already synchronised
- done, out, 1, sequence completed successfully (sticky until next start/reset)
- error, out, 1, sequence aborted on retry exhaustion (sticky until next start/reset)
- err_idx, out, IDX_W, table index of the failing entry
- tbl_idx, out, IDX_W, index into config table
- tbl_entry, in, 16, {reg_addr[15:8], data[7:0]}; combinational from tbl_idx
- i2c_chip_addr, out, 7, to i2c_master chip_addr
- i2c_reg_addr, out, 8, to i2c_master reg_addr
- i2c_data_in, out, 8, to i2c_master data_in
- i2c_write_en, out, 1, one-cycle write request pulse
- i2c_read_en, out, 1, one-cycle read request pulse (used only with the optional feature)
- i2c_busy, in, 1, from i2c_master busy
- i2c_status, in, 3, from i2c_master status; 0 = OK
- i2c_data_out, in, 8, from i2c_master data_out

Behaviour:
- **Reset values:** state = S_IDLE; done = 0; error = 0; err_idx = 0; tbl_idx = 0; i2c_write_en = 0; i2c_read_en = 0; i2c_reg_addr = 0; i2c_data_in = 0; i2c_chip_addr = CHIP_ADDR. Reset asserted mid-transaction drops every request line on the next edge. The bus is left to i2c_master's own reset.
- **S_IDLE:** if start && hpd, then clear done/error, set tbl_idx = 0, retry count = 0, go to S_LOAD. If start is high and hpd is low, stay in S_IDLE.
- **S_LOAD:** register tbl_entry into i2c_reg_addr/i2c_data_in, go to S_ISSUE. One cycle of ROM latency is tolerated.
- **S_ISSUE:** i2c_write_en = 1 for exactly one cycle, load the timeout counter, go to S_WAIT.
- **S_WAIT:** the first cycle after the pulse is ignored (i2c_busy may not yet be high). Thereafter, when i2c_busy = 0, go to S_CHECK. If the timeout counter reaches 0, treat the transaction as failed.
- **S_CHECK:**
  - If status == 0 (and not timed out), go to S_DELAY.
  - Otherwise, if retries < MAX_RETRIES, increment retries and go to S_DELAY with the same index.
  - Otherwise set error = 1, err_idx = tbl_idx, go to S_IDLE.
- **S_DELAY:** count TXN_DELAY cycles (TXN_DELAY = 0 means zero extra cycles). Then:
  - Last entry succeeded (tbl_idx == NUM_REGS-1): set done = 1, go to S_IDLE.
  - Entry succeeded otherwise: tbl_idx += 1, retries = 0, go to S_LOAD.
  - Retry pending: go to S_LOAD without changing tbl_idx.
- **hpd deasserted while not in S_IDLE:** finish the outstanding i2c transaction (never pulse a new request), then return to S_IDLE with done = 0 and error = 0.
- **start during a sequence:** ignored.
- **Completion latency:** the write pulse never coincides with i2c_busy = 1. Minimum latency from start to done, per entry = 4 + i2c time + TXN_DELAY.
- **Counter widths:** the delay counter is $clog2(TXN_DELAY+1) bits and the timeout counter is $clog2(TIMEOUT+1) bits. Both count down and saturate at 0.

Optional Feature:
- Macro: ADV7513_INIT_VERIFY_EN.
- **With the macro defined:** after each successful write, S_VERIFY issues an i2c_read_en pulse on the same reg_addr and waits using the same rules as S_WAIT. If status != 0 or i2c_data_out != the written data, the entry counts as a failure and follows the S_CHECK retry path (the retry rewrites, then re-reads).
- **Without the macro:** there is no verify state; i2c_read_en is tied to 0.

Decomposition:
- **Package adv7513_pkg:** state enum encoding; table entry field offsets (REG_HI = 15, REG_LO = 8, DAT_HI = 7, DAT_LO = 0); I2C_STATUS_OK = 3'd0.
- **Sub-module adv7513_init_rom:** combinational case table (tbl_idx -> tbl_entry). Default entries are the power-up writes (0x41 <= 0x10, 0x98 <= 0x03, 0x9A <= 0xE0, 0x9C <= 0x30, 0x9D <= 0x61, 0xA2 <= 0xA4, 0xA3 <= 0xA4, 0xE0 <= 0xD0, 0xF9 <= 0x00, 0x15 <= 0x00, 0x16 <= 0x30, 0x17 <= 0x02, 0x18 <= 0x46, 0xAF <= 0x06, 0xBA <= 0x60, 0xD6 <= 0xC0). The sequencer instantiates it.

Test Plan:
- **Happy path:** hpd = 1, start pulse; BFM (bus functional model of i2c_master) holds busy for 50 cycles, status 0, TXN_DELAY = 4 -> 16 write pulses with reg/data matching the ROM in order, done = 1, error = 0.
- **Single NACK:** status = 3'd1 on entry 5, first attempt only -> entry 5 written twice, sequence completes, done = 1.
- **Retry exhaustion:** entry 2 always returns status 1, MAX_RETRIES = 3 -> exactly 4 attempts on 0x9A, error = 1, err_idx = 2, done = 0, no further pulses.
- **Hot-plug drop:** hpd falls mid-entry 7 while busy -> no new pulse after busy clears, state idle, done = 0. Restarting with hpd = 1 begins again at index 0.
- **Reset during S_WAIT:** reset = 1 for 1 cycle -> next edge write_en = 0, done = 0, error = 0, tbl_idx = 0.
- **Verify (macro on):** BFM returns 0xE1 on readback of 0x9A -> rewrite plus re-read occurs. Persistent mismatch -> error = 1, err_idx = 2.
